// File: rtl/tx_iq_pkg.sv
// Shared definitions for the TX I/Q elastic buffer and its DAC-side consumer.
// Holds the FSM states, the pointer-width helper and the {I,Q} packing convention.
package tx_iq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Word slots inside a packed {I,Q} sample: I sits in the upper DATA_W bits.
  localparam int unsigned IQ_I_SLOT = 1;
  localparam int unsigned IQ_Q_SLOT = 0;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/tx_iq_fifo_if.sv
// Sample-in / stream-out / status bundle of tx_iq_fifo.
// slave is the FIFO side, master is the producer/consumer side.
interface tx_iq_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                  i_enable;
  logic                  i_clr_flags;
  logic                  i_wr;
  logic [DATA_W-1:0]     i_data_I;
  logic [DATA_W-1:0]     i_data_Q;
  logic [2*DATA_W-1:0]   o_tdata;
  logic                  o_tvalid;
  logic                  i_tready;
  logic [LVL_W-1:0]      o_level;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_overflow;
  logic                  o_underflow;
  logic                  o_int;

  modport master (
    output i_enable, i_clr_flags, i_wr, i_data_I, i_data_Q, i_tready,
    input  o_tdata, o_tvalid, o_level, o_full, o_empty, o_overflow, o_underflow, o_int
  );

  modport slave (
    input  i_enable, i_clr_flags, i_wr, i_data_I, i_data_Q, i_tready,
    output o_tdata, o_tvalid, o_level, o_full, o_empty, o_overflow, o_underflow, o_int
  );

endinterface

// File: rtl/tx_iq_ram.sv
// Storage for tx_iq_fifo: one synchronous write port, one combinational read port.
// No reset; contents are meaningful only where the FIFO pointers say so.
module tx_iq_ram
  import tx_iq_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_iq_fifo.sv
// Elastic buffer between the TX DDS and the DAC stream, with prefill gating
// and sticky overflow/underflow status.
module tx_iq_fifo
  import tx_iq_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PRIME_LVL = 8
) (
  input logic         clk,
  input logic         rst,
  tx_iq_fifo_if.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLvl  = LW'(DEPTH);
  localparam logic [LW-1:0] PrimeLvl = LW'(PRIME_LVL);

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full, empty, tvalid, rd_ok, wr_ok;
  logic [2*DATA_W-1:0] wdata, rdata;

  assign full   = (level_q == FullLvl);
  assign empty  = (level_q == '0);
  assign tvalid = (state_q == STREAM) && !empty;
  assign rd_ok  = tvalid && bus.i_tready;
  // A write into a full buffer still lands when the head leaves in the same cycle.
  assign wr_ok  = bus.i_wr && bus.i_enable && (!full || rd_ok);

  always_comb begin
    wdata = '0;
    wdata[IQ_I_SLOT*DATA_W +: DATA_W] = bus.i_data_I;
    wdata[IQ_Q_SLOT*DATA_W +: DATA_W] = bus.i_data_Q;
  end

  tx_iq_ram #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    // Clear first so a same-cycle set below wins.
    if (bus.i_clr_flags) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end

    if (!bus.i_enable) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_ok && !rd_ok) begin
        level_d = level_q + LW'(1);
      end else if (rd_ok && !wr_ok) begin
        level_d = level_q - LW'(1);
      end
      if (bus.i_wr && full && !rd_ok) ovf_d = 1'b1;

      case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: if (level_q >= PrimeLvl) state_d = STREAM;
        STREAM: begin
          if (empty && bus.i_tready) begin
            udf_d   = 1'b1;
            state_d = PRIME;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.o_tdata     = rdata;
  assign bus.o_tvalid    = tvalid;
  assign bus.o_level     = level_q;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
  assign bus.o_int       = ovf_q | udf_q;

endmodule

// File: tb/tb_tx_iq_fifo.sv
// Bench for tx_iq_fifo: directed vector table, hand sequences for the corner cases,
// and random traffic checked against a queue-based reference model.
module tb_tx_iq_fifo;
  import tx_iq_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PLVL  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tx_iq_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  tx_iq_fifo #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .PRIME_LVL (PLVL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of packed {I,Q}, phase 0=idle 1=prime 2=stream, sticky flags.
  bit [63:0] mq[$];
  int        mphase = 0;
  bit        movf = 1'b0;
  bit        mudf = 1'b0;

  bit        en, clr, wr, rdy;
  bit [31:0] di, dq;

  typedef struct {
    bit        en, clr, wr, rdy;
    bit [31:0] i, q;
    int        lvl;
    bit        valid, full, ovf;
    bit        chk_d;
    bit [63:0] d;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input bit e, input bit c, input bit w, input bit r,
                              input bit [31:0] i, input bit [31:0] q, input int lvl,
                              input bit v, input bit f, input bit o, input bit cd,
                              input bit [63:0] d);
    vec_t x;
    x.en = e; x.clr = c; x.wr = w; x.rdy = r; x.i = i; x.q = q; x.lvl = lvl;
    x.valid = v; x.full = f; x.ovf = o; x.chk_d = cd; x.d = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_valid();
    return (mphase == 2) && (mq.size() != 0);
  endfunction

  task automatic check_model();
    chk("m_level", 64'(bus.o_level), 64'(mq.size()));
    chk("m_valid", 64'(bus.o_tvalid), 64'(m_valid()));
    chk("m_full", 64'(bus.o_full), 64'(mq.size() == DEPTH));
    chk("m_empty", 64'(bus.o_empty), 64'(mq.size() == 0));
    chk("m_ovf", 64'(bus.o_overflow), 64'(movf));
    chk("m_udf", 64'(bus.o_underflow), 64'(mudf));
    chk("m_int", 64'(bus.o_int), 64'(movf | mudf));
    if (m_valid()) chk("m_tdata", bus.o_tdata, mq[0]);
  endtask

  task automatic model_edge();
    int n  = mq.size();
    bit rd = m_valid() && rdy;
    bit wa = wr && en && (n < DEPTH || rd);
    if (clr) begin
      movf = 1'b0;
      mudf = 1'b0;
    end
    if (!en) begin
      mq.delete();
      mphase = 0;
      return;
    end
    if (wr && n == DEPTH && !rd) movf = 1'b1;
    if (rd) void'(mq.pop_front());
    if (wa) mq.push_back({di, dq});
    case (mphase)
      0: mphase = 1;
      1: if (n >= PLVL) mphase = 2;
      default: if (n == 0 && rdy) begin
        mudf   = 1'b1;
        mphase = 1;
      end
    endcase
  endtask

  task automatic cycle(input bit e, input bit c, input bit w, input bit r,
                       input bit [31:0] i, input bit [31:0] q);
    en = e; clr = c; wr = w; rdy = r; di = i; dq = q;
    bus.i_enable    = e;
    bus.i_clr_flags = c;
    bus.i_wr        = w;
    bus.i_tready    = r;
    bus.i_data_I    = i;
    bus.i_data_Q    = q;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    // Directed table: prime threshold, fill to full, overflow, clear, write+read when full.
    for (int k = 0; k < 8; k++)
      vt[k] = mk(1, 0, 1, 0, 32'(k + 1), 32'('h101 + k), k + 1, 0, 0, 0, 0, 64'h0);
    vt[8] = mk(1, 0, 0, 0, 0, 0, 8, 1, 0, 0, 1, 64'h00000001_00000101);
    for (int j = 9; j <= 16; j++)
      vt[j] = mk(1, 0, 1, 0, 32'(j), 32'('h100 + j), j, 1, (j == 16), 0, 1,
                 64'h00000001_00000101);
    vt[17] = mk(1, 0, 1, 0, 32'h11, 32'h111, 16, 1, 1, 1, 1, 64'h00000001_00000101);
    vt[18] = mk(1, 1, 0, 0, 0, 0, 16, 1, 1, 0, 1, 64'h00000001_00000101);
    vt[19] = mk(1, 0, 1, 1, 32'h12, 32'h112, 16, 1, 1, 0, 1, 64'h00000002_00000102);

    en = 0; clr = 0; wr = 0; rdy = 0; di = 0; dq = 0;
    bus.i_enable = 0; bus.i_clr_flags = 0; bus.i_wr = 0; bus.i_tready = 0;
    bus.i_data_I = 0; bus.i_data_Q = 0;

    #12;
    chk("rst_level", 64'(bus.o_level), 64'd0);
    chk("rst_valid", 64'(bus.o_tvalid), 64'd0);
    chk("rst_empty", 64'(bus.o_empty), 64'd1);
    chk("rst_full", 64'(bus.o_full), 64'd0);
    chk("rst_ovf", 64'(bus.o_overflow), 64'd0);
    chk("rst_udf", 64'(bus.o_underflow), 64'd0);
    chk("rst_int", 64'(bus.o_int), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 20; k++) begin
      cycle(vt[k].en, vt[k].clr, vt[k].wr, vt[k].rdy, vt[k].i, vt[k].q);
      chk($sformatf("vec%0d_level", k), 64'(bus.o_level), 64'(vt[k].lvl));
      chk($sformatf("vec%0d_valid", k), 64'(bus.o_tvalid), 64'(vt[k].valid));
      chk($sformatf("vec%0d_full", k), 64'(bus.o_full), 64'(vt[k].full));
      chk($sformatf("vec%0d_ovf", k), 64'(bus.o_overflow), 64'(vt[k].ovf));
      if (vt[k].chk_d) chk($sformatf("vec%0d_tdata", k), bus.o_tdata, vt[k].d);
    end

    // Drain: 2..16 then the sample written alongside the read; the dropped one never shows.
    for (int s = 2; s <= 16; s++) begin
      chk($sformatf("drain%0d", s), bus.o_tdata, {32'(s), 32'('h100 + s)});
      cycle(1, 0, 0, 1, 0, 0);
    end
    chk("drain_last", bus.o_tdata, 64'h00000012_00000112);
    cycle(1, 0, 0, 1, 0, 0);
    chk("drained_empty", 64'(bus.o_empty), 64'd1);
    cycle(1, 0, 0, 1, 0, 0);
    chk("udf_set", 64'(bus.o_underflow), 64'd1);
    chk("udf_valid", 64'(bus.o_tvalid), 64'd0);
    chk("udf_int", 64'(bus.o_int), 64'd1);

    // Re-prime after underflow.
    for (int k = 0; k < 8; k++) cycle(1, 0, 1, 0, 32'('h20 + k), 32'('h120 + k));
    chk("reprime_wait", 64'(bus.o_tvalid), 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("reprime_valid", 64'(bus.o_tvalid), 64'd1);
    chk("reprime_tdata", bus.o_tdata, 64'h00000020_00000120);

    // Clear collides with a fresh overflow: set wins, then clear alone drops it.
    for (int k = 0; k < 8; k++) cycle(1, 0, 1, 0, 32'('h30 + k), 32'('h130 + k));
    cycle(1, 1, 1, 0, 32'h99, 32'h199);
    chk("clr_set_ovf", 64'(bus.o_overflow), 64'd1);
    chk("clr_set_udf", 64'(bus.o_underflow), 64'd0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("clr_only_ovf", 64'(bus.o_overflow), 64'd0);
    chk("clr_only_int", 64'(bus.o_int), 64'd0);

    // Enable drop at level 5 flushes on the next edge and discards the in-flight write.
    cycle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(1, 0, 1, 0, 32'('h40 + k), 32'('h140 + k));
    chk("lvl5", 64'(bus.o_level), 64'd5);
    cycle(0, 0, 1, 0, 32'h55, 32'h155);
    chk("flush_level", 64'(bus.o_level), 64'd0);
    chk("flush_empty", 64'(bus.o_empty), 64'd1);
    chk("flush_valid", 64'(bus.o_tvalid), 64'd0);
    chk("flush_state", 64'(dut.state_q), 64'(IDLE));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
            $urandom, $urandom);
    end

    // Asynchronous reset mid-stream with a sticky flag set.
    for (int k = 0; k < 20; k++) cycle(1, 0, 1, 0, 32'('h60 + k), 32'('h160 + k));
    chk("pre_rst_ovf", 64'(bus.o_overflow), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_level", 64'(bus.o_level), 64'd0);
    chk("arst_valid", 64'(bus.o_tvalid), 64'd0);
    chk("arst_empty", 64'(bus.o_empty), 64'd1);
    chk("arst_full", 64'(bus.o_full), 64'd0);
    chk("arst_ovf", 64'(bus.o_overflow), 64'd0);
    chk("arst_udf", 64'(bus.o_underflow), 64'd0);
    chk("arst_int", 64'(bus.o_int), 64'd0);
    mq.delete();
    mphase = 0; movf = 0; mudf = 0;
    en = 0; wr = 0; clr = 0; rdy = 0;
    bus.i_enable = 0; bus.i_wr = 0; bus.i_clr_flags = 0; bus.i_tready = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 0, 1, 0, 32'h77, 32'h177);
    chk("post_rst_level", 64'(bus.o_level), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_iq_fifo.md
# tx_iq_fifo

Elastic buffer directly downstream of the `IP_TX_DDS` core. It captures each I/Q sample pair strobed by `WritEn_2FIFO_o` and drains the pairs to the DAC/transmit stream over a valid/ready handshake. A prefill state machine holds the output until the buffer reaches a configurable level. Sticky overflow and underflow flags are exported for the AIP interrupt/status path.

## Interface
Parameters:
- `DATA_W`, 32, width of each of I and Q.
- `DEPTH`, 16, entries; must be a power of two, ≥4.
- `PRIME_LVL`, 8, occupancy required before streaming starts or restarts; 1..DEPTH.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_enable`  in  1  run enable; low flushes the FIFO and holds IDLE.
- `i_clr_flags`  in  1  synchronous clear of the sticky flags.
- `i_wr`  in  1  sample strobe (from `WritEn_2FIFO_o`).
- `i_data_I`  in  DATA_W  in-phase sample.
- `i_data_Q`  in  DATA_W  quadrature sample.
- `o_tdata`  out  2*DATA_W  `{I,Q}`; I occupies the MSBs.
- `o_tvalid`  out  1  output sample valid.
- `i_tready`  in  1  consumer ready.
- `o_level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `o_full` / `o_empty`  out  1  level==DEPTH / level==0.
- `o_overflow`  out  1  sticky: a write was dropped.
- `o_underflow`  out  1  sticky: the consumer was starved while streaming.
- `o_int`  out  1  `o_overflow | o_underflow`.

## Operation
- Storage: DEPTH×(2*DATA_W) array with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. A registered `level` counter holds occupancy.
- Write accepted (`wr_ok`): `i_wr && i_enable && (!full || rd_ok)`. When full, a write in the same cycle as a read is accepted.
- Read accepted (`rd_ok`): `o_tvalid && i_tready`.
- Level update: `+1` on `wr_ok` only, `−1` on `rd_ok` only, unchanged when both or neither occur.
- A write while full without a same-cycle read is dropped, sets `o_overflow`, and leaves the pointers unchanged.
- State machine (2-bit encoding):
  - IDLE: entered whenever `i_enable`=0; pointers and level are forced to 0. Goes to PRIME when `i_enable`=1.
  - PRIME: `o_tvalid`=0; writes accepted. Goes to STREAM when registered `level` ≥ PRIME_LVL.
  - STREAM: `o_tvalid` = !empty. If empty with `i_tready`=1, sets `o_underflow` and returns to PRIME. Otherwise stays in STREAM.
- `i_enable` falling has priority over all other events: the flush happens on the next edge and any in-flight write is discarded.
- `i_clr_flags` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- `o_tdata` = `mem[rd_ptr]`, combinational (first-word-fall-through). It is undefined while `o_tvalid`=0.

## Timing
- Reset values: state=IDLE, pointers=0, level=0, `o_tvalid`=0, `o_empty`=1, `o_full`=0, `o_overflow`=0, `o_underflow`=0, `o_int`=0, `o_level`=0.
- Write at edge k: `o_level` reflects it after edge k. When STREAM is active, `o_tvalid` can rise in the cycle after edge k (latency 1).
- PRIME→STREAM is taken at the edge after the level reaches PRIME_LVL, so the first `o_tvalid` appears 1 cycle after the level hits the threshold.
- Once `o_tvalid` is high, `o_tdata` must remain stable until `rd_ok`.
- Flags assert the cycle after the causing edge and are registered. `o_int` is a combinational OR of the registered flags.
- Asynchronous reset mid-stream: all outputs return to reset values immediately. Buffer contents are don't-care.

## Structure
- Shared package `tx_iq_pkg`:
  - state enum `{IDLE, PRIME, STREAM}`;
  - a function returning the pointer width from DEPTH;
  - the `{I,Q}` packing convention, also used by the DAC-side consumer.
- Sub-module `tx_iq_ram`: a 1-write/1-async-read register array holding the storage. It has no reset.

## Test plan
- Reset, then `i_enable`=1 with 7 writes (I=0x1..0x7, Q=0x101..0x107) → `o_level`=7, `o_tvalid`=0. The 8th write → `o_tvalid`=1 one cycle later, `o_tdata`=0x00000001_00000101.
- DEPTH=16, 17 writes with `i_tready`=0 → `o_full`=1, `o_overflow`=1, `o_int`=1. The 17th sample is absent when the FIFO is drained: the sequence ends at the 16th sample.
- Full FIFO, `i_wr`=1 and `i_tready`=1 in the same cycle → write accepted, `o_level` stays 16, no overflow.
- In STREAM with 8 entries, `i_tready`=1 continuously and no writes → 8 reads in order, then `o_underflow`=1, `o_tvalid`=0. Writing 8 more entries resumes `o_tvalid`.
- `i_clr_flags`=1 together with a new overflow event → `o_overflow` stays 1. `i_clr_flags` alone on the next cycle → 0.
- `i_enable` drops while level=5 → next cycle `o_level`=0, `o_empty`=1, state IDLE. Assert `rst` low mid-stream → all outputs at reset values without waiting for a clock edge.
